game_round_timer: RTL and testbench



---
 rtl/game_round_timer.sv | 136 +++++++++++++
 tb/tb_game_round_timer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_timer.sv
// game_round_timer: two-digit BCD countdown of whole seconds for the game
// controller. Runs while enable is high, pauses on enable low, and holds
// time_out once the count reaches 00 until reconfig, load or reset.
module game_round_timer #(
  parameter int CLKS_PER_SEC = 50000000,
  parameter int DEFAULT_TENS = 6,
  parameter int DEFAULT_ONES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       reconfig,
  input  logic       load,
  input  logic [3:0] toggle_switch,
  output logic       time_out,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       tick,
  output logic       running
);

  // A one-cycle second still needs a one-bit prescaler to keep widths legal.
  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);
  localparam logic [3:0] DEF_TENS = 4'(DEFAULT_TENS);
  localparam logic [3:0] DEF_ONES = 4'(DEFAULT_ONES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          time_out_q;
  logic          running_q;
  logic          count_zero;
  logic          last_second;

  assign count_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
  // The decrement that lands on 00 (also covers an impossible 00 in RUN).
  assign last_second = (tens_q == 4'd0) && (ones_q <= 4'd1);

  // Next-state: reconfig beats load, load beats the state machine.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (reconfig) begin
      tens_d  = DEF_TENS;
      ones_d  = DEF_ONES;
      presc_d = '0;
      state_d = ST_IDLE;
    end else if (load) begin
      tens_d  = (toggle_switch > 4'd9) ? 4'd9 : toggle_switch;
      ones_d  = 4'd0;
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = count_zero ? ST_EXPIRED : ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            // Prescaler is deliberately kept so the partial second resumes.
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (!count_zero) begin
              tick_d = 1'b1;
              if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end
            end
            if (last_second) begin
              state_d = ST_EXPIRED;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (enable) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; status flags decode the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tens_q     <= DEF_TENS;
      ones_q     <= DEF_ONES;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      time_out_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      time_out_q <= (state_d == ST_EXPIRED);
      running_q  <= (state_d == ST_RUN);
    end
  end

  assign time_out = time_out_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign tick     = tick_q;
  assign running  = running_q;

endmodule

// File: tb/tb_game_round_timer.sv
// Bench for game_round_timer with CLKS_PER_SEC=4 and defaults 6/0.
// Stimulus pushes expected tick events and output snapshots into queues;
// independent monitors pop and compare them.
module tb_game_round_timer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       reconfig;
  logic       load;
  logic [3:0] toggle_switch;
  logic       time_out;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tick;
  logic       running;

  game_round_timer #(
    .CLKS_PER_SEC(4),
    .DEFAULT_TENS(6),
    .DEFAULT_ONES(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .reconfig(reconfig),
    .load(load),
    .toggle_switch(toggle_switch),
    .time_out(time_out),
    .tens(tens),
    .ones(ones),
    .tick(tick),
    .running(running)
  );

  typedef struct {
    int         cyc;
    logic [3:0] t;
    logic [3:0] o;
    logic       to;
    logic       run;
  } tick_exp_t;

  typedef struct {
    string      name;
    logic [3:0] t;
    logic [3:0] o;
    logic       to;
    logic       run;
    logic       tk;
  } snap_t;

  tick_exp_t tq[$];
  snap_t     sq[$];
  event      snap_ev;
  int        cyc;
  int        checks;
  int        errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick monitor: every cycle, tick must be high exactly when a tick is due.
  always @(negedge clk) begin
    logic      due;
    tick_exp_t e;
    due = (tq.size() > 0) && (tq[0].cyc == cyc);
    checks++;
    if (tick !== due) begin
      errors++;
      $display("FAIL tick_timing cyc=%0d: tick=%0b want %0b", cyc, tick, due);
    end
    if (due) begin
      e = tq.pop_front();
      if (tick === 1'b1) begin
        checks++;
        if (tens !== e.t || ones !== e.o || time_out !== e.to || running !== e.run) begin
          errors++;
          $display("FAIL tick_value cyc=%0d: got %0d%0d to=%0b run=%0b want %0d%0d to=%0b run=%0b",
                   cyc, tens, ones, time_out, running, e.t, e.o, e.to, e.run);
        end else begin
          $display("tick cyc=%0d count=%0d%0d time_out=%0b", cyc, tens, ones, time_out);
        end
      end
    end
  end

  // Snapshot monitor: compares all outputs whenever stimulus requests it.
  always begin
    snap_t s;
    @(snap_ev);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      checks++;
      if (tens !== s.t || ones !== s.o || time_out !== s.to || running !== s.run || tick !== s.tk) begin
        errors++;
        $display("FAIL %s: got %0d%0d to=%0b run=%0b tick=%0b want %0d%0d to=%0b run=%0b tick=%0b",
                 s.name, tens, ones, time_out, running, tick, s.t, s.o, s.to, s.run, s.tk);
      end else begin
        $display("snap %s: count=%0d%0d to=%0b run=%0b", s.name, tens, ones, time_out, running);
      end
    end
  end

  task automatic expect_now(input string name, input logic [3:0] t, input logic [3:0] o,
                            input logic to, input logic run, input logic tk);
    snap_t s;
    s.name = name; s.t = t; s.o = o; s.to = to; s.run = run; s.tk = tk;
    sq.push_back(s);
    ->snap_ev;
    #1;
  endtask

  task automatic snap_at_neg(input string name, input logic [3:0] t, input logic [3:0] o,
                             input logic to, input logic run, input logic tk);
    @(negedge clk);
    expect_now(name, t, o, to, run, tk);
  endtask

  task automatic push_tick(input int c, input logic [3:0] t, input logic [3:0] o,
                           input logic to, input logic run);
    tick_exp_t e;
    e.cyc = c; e.t = t; e.o = o; e.to = to; e.run = run;
    tq.push_back(e);
  endtask

  // Advance to 1 time unit after the posedge that makes cyc == c.
  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hand-computed count after each tick of a run from 10.
  logic [7:0] run_cnt [10] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
                               8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  initial begin
    int         k;
    int         m;
    int         r;
    int         p;
    int         q;
    logic [7:0] v;
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; enable = 1'b0; reconfig = 1'b0; load = 1'b0; toggle_switch = 4'd0;
    #1 rst = 1'b0;
    #1;
    expect_now("reset_state", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Idle with enable low: count stays at the default.
    at_cycle(21);
    snap_at_neg("idle_20", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);

    // Full run from 10 down to 00.
    at_cycle(22);
    k = cyc;
    load = 1'b1; toggle_switch = 4'd1;
    at_cycle(k + 1);
    load = 1'b0; enable = 1'b1;
    snap_at_neg("load_10", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      v = run_cnt[j];
      push_tick(k + 2 + 4 * (j + 1), v[7:4], v[3:0], (j == 9), (j != 9));
    end
    at_cycle(k + 2);
    snap_at_neg("run_start", 4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
    at_cycle(k + 43);
    snap_at_neg("expired_hold", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Reconfig from EXPIRED with enable still high.
    m = cyc;
    reconfig = 1'b1;
    at_cycle(m + 1);
    reconfig = 1'b0;
    snap_at_neg("reconfig_idle", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
    at_cycle(m + 2);
    snap_at_neg("reconfig_run", 4'd6, 4'd0, 1'b0, 1'b1, 1'b0);

    // Pause mid-second from 10 and resume the partial second.
    load = 1'b1; toggle_switch = 4'd1;
    at_cycle(m + 3);
    load = 1'b0;
    snap_at_neg("reload_10", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    r = m + 4;
    at_cycle(r + 2);
    enable = 1'b0;
    at_cycle(r + 5);
    snap_at_neg("pause_a", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    at_cycle(r + 9);
    snap_at_neg("pause_b", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    push_tick(r + 12, 4'd0, 4'd9, 1'b0, 1'b1);
    at_cycle(r + 10);
    snap_at_neg("resume", 4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
    at_cycle(r + 13);

    // Load saturation, then load 0 with enable going straight to EXPIRED.
    p = cyc;
    enable = 1'b0; load = 1'b1; toggle_switch = 4'd12;
    at_cycle(p + 1);
    toggle_switch = 4'd0; enable = 1'b1;
    snap_at_neg("load_sat", 4'd9, 4'd0, 1'b0, 1'b0, 1'b0);
    at_cycle(p + 2);
    load = 1'b0;
    snap_at_neg("load_zero", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    at_cycle(p + 3);
    snap_at_neg("zero_expired", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    at_cycle(p + 8);
    snap_at_neg("zero_hold", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-second while showing 07.
    q = cyc;
    load = 1'b1; toggle_switch = 4'd1;
    at_cycle(q + 1);
    load = 1'b0;
    push_tick(q + 6, 4'd0, 4'd9, 1'b0, 1'b1);
    push_tick(q + 10, 4'd0, 4'd8, 1'b0, 1'b1);
    push_tick(q + 14, 4'd0, 4'd7, 1'b0, 1'b1);
    at_cycle(q + 16);
    rst = 1'b0;
    #1;
    expect_now("async_reset", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    rst = 1'b1;
    at_cycle(q + 22);
    snap_at_neg("post_reset", 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);

    checks++;
    if (tq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: ticks_left=%0d snaps_left=%0d want 0 and 0", tq.size(), sq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
